// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types and GF(2^8) constant multipliers
package aes_pkg;

  typedef logic [3:0][3:0][7:0] state_t;  // [row][col] byte matrix
  typedef logic [3:0][7:0]      col_t;    // [row] bytes of one column

  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/inv_mix_columns_col.sv
// rtl/inv_mix_columns_col.sv - combinational InvMixColumns of one column
module inv_mix_columns_col
  import aes_pkg::*;
(
  input  col_t col_i,
  output col_t col_o
);

  always_comb begin
    col_o[0] = gf_mul_0e(col_i[0]) ^ gf_mul_0b(col_i[1]) ^ gf_mul_0d(col_i[2]) ^ gf_mul_09(col_i[3]);
    col_o[1] = gf_mul_09(col_i[0]) ^ gf_mul_0e(col_i[1]) ^ gf_mul_0b(col_i[2]) ^ gf_mul_0d(col_i[3]);
    col_o[2] = gf_mul_0d(col_i[0]) ^ gf_mul_09(col_i[1]) ^ gf_mul_0e(col_i[2]) ^ gf_mul_0b(col_i[3]);
    col_o[3] = gf_mul_0b(col_i[0]) ^ gf_mul_0d(col_i[1]) ^ gf_mul_09(col_i[2]) ^ gf_mul_0e(col_i[3]);
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - iterative InvMixColumns, COLS_PER_CYCLE columns per busy cycle
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

  fsm_e       state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  state_t     work_q, work_d;
  state_t     out_q, out_d;

  logic [1:0] sel     [COLS_PER_CYCLE];
  col_t       col_in  [COLS_PER_CYCLE];
  col_t       col_out [COLS_PER_CYCLE];

  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      sel[g] = col_idx_q + 2'(g);
      for (int r = 0; r < 4; r++) begin
        col_in[g][r] = work_q[r][sel[g]];
      end
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    inv_mix_columns_col u_col (
      .col_i(col_in[g]),
      .col_o(col_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    work_d    = work_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = in;
          col_idx_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          for (int r = 0; r < 4; r++) begin
            out_d[r][sel[g]] = col_out[g][r];
          end
        end
        col_idx_d = col_idx_q + STEP;
        if (col_idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Ready passes straight through so a new state can overlap the output handshake.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d    = in;
            col_idx_d = 2'd0;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_idx_q <= 2'd0;
      work_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      work_q    <= work_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - self-checking bench over COLS_PER_CYCLE = 1, 2, 4
module tb_inv_mix_columns_seq;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  state_t     in_s  [3];
  state_t     out_s [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in(in_s[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out(out_s[g])
    );
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix product: row r uses coef[(j - r) mod 4] against row j.
  function automatic state_t circ_mul(input state_t s, input logic [7:0] coef [4]);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[r][c] = 8'h00;
        for (int j = 0; j < 4; j++) o[r][c] = o[r][c] ^ gf_mul(coef[(j - r) & 3], s[j][c]);
      end
    return o;
  endfunction

  function automatic state_t ref_inv(input state_t s);
    logic [7:0] coef [4];
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    return circ_mul(s, coef);
  endfunction

  function automatic state_t ref_mix(input state_t s);
    logic [7:0] coef [4];
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    return circ_mul(s, coef);
  endfunction

  function automatic state_t cols(input logic [31:0] c0, input logic [31:0] c1,
                                  input logic [31:0] c2, input logic [31:0] c3);
    state_t s;
    logic [31:0] cw [4];
    cw = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = cw[c][31 - 8*r -: 8];
    return s;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = 8'($urandom);
    return s;
  endfunction

  // Accept x on DUT k, wait for out_valid (bounded), return result and latency, then handshake.
  task automatic run_one(input int k, input state_t x, output state_t y, output int lat);
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_s[k]     = x;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_s[k]     = rand_state();
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[k]) begin
      checks++; errors++;
      $display("FAIL run_one_timeout dut=%0d out_valid never rose", k);
    end
    y = out_s[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 3'b111;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_s[k] !== '0) begin
        errors++;
        $display("FAIL reset dut=%0d in_ready=%b out_valid=%b out=%h required 1 0 0",
                 k, in_ready[k], out_valid[k], out_s[k]);
      end
    end
    rst = 3'b000;
  endtask

  task automatic test_single_column();
    state_t y;
    int lat;
    run_one(0, cols(32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101), y, lat);
    checks++;
    if (y !== cols(32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101)) begin
      errors++;
      $display("FAIL single_column out=%h", y);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL single_column_latency got=%0d required=4", lat);
    end
  endtask

  task automatic test_known_vectors();
    state_t x, e, y;
    int lat;
    x = cols(32'h9fdc589d, 32'hd5d5d7d6, 32'hc6c6c6c6, 32'h8e4da1bc);
    e = cols(32'hf20a225c, 32'hd4d4d4d5, 32'hc6c6c6c6, 32'hdb135345);
    for (int k = 0; k < 3; k++) begin
      run_one(k, x, y, lat);
      checks++;
      if (y !== e) begin
        errors++;
        $display("FAIL known_vector dut=%0d got=%h required=%h", k, y, e);
      end
      checks++;
      if (lat !== (4 >> k)) begin
        errors++;
        $display("FAIL known_latency dut=%0d got=%0d required=%0d", k, lat, 4 >> k);
      end
    end
  endtask

  task automatic test_backpressure();
    state_t x, held;
    int cnt;
    bit bad;
    x = rand_state();
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_s[0] = x;
    @(negedge clk);
    // in_valid stays high with new data while BUSY; it must be ignored
    in_s[0] = rand_state();
    @(negedge clk);
    in_s[0] = rand_state();
    in_valid[0] = 1'b0;
    cnt = 0;
    while (!out_valid[0] && cnt < 20) begin
      @(negedge clk);
      in_s[0] = rand_state();
      cnt++;
    end
    held = out_s[0];
    checks++;
    if (held !== ref_inv(x)) begin
      errors++;
      $display("FAIL backpressure_result got=%h required=%h", held, ref_inv(x));
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_s[0] !== held) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL backpressure_hold out_valid=%b in_ready=%b out=%h required 1 0 %h",
               out_valid[0], in_ready[0], out_s[0], held);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release out_valid=%b in_ready=%b required 0 1",
               out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_back_to_back();
    state_t x1, x2;
    int cnt;
    x1 = rand_state();
    x2 = rand_state();
    @(negedge clk);
    in_valid[0]  = 1'b1;
    in_s[0]      = x1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_s[0] = x2;
    cnt = 0;
    while (!out_valid[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b1 || out_s[0] !== ref_inv(x1)) begin
      errors++;
      $display("FAIL b2b_first out_valid=%b in_ready=%b out=%h required 1 1 %h",
               out_valid[0], in_ready[0], out_s[0], ref_inv(x1));
    end
    cnt = 0;
    do begin
      @(negedge clk);
      in_valid[0] = 1'b0;
      cnt++;
    end while (!out_valid[0] && cnt < 20);
    checks++;
    if (cnt !== 5) begin
      errors++;
      $display("FAIL b2b_interval got=%0d required=5", cnt);
    end
    checks++;
    if (out_s[0] !== ref_inv(x2)) begin
      errors++;
      $display("FAIL b2b_second got=%h required=%h", out_s[0], ref_inv(x2));
    end
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_midop();
    state_t x, y;
    int lat;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_s[0] = rand_state();
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0 || out_s[0] !== '0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_midop out_valid=%b out=%h in_ready=%b required 0 0 1",
               out_valid[0], out_s[0], in_ready[0]);
    end
    rst[0] = 1'b0;
    x = rand_state();
    run_one(0, x, y, lat);
    checks++;
    if (y !== ref_inv(x) || lat !== 4) begin
      errors++;
      $display("FAIL reset_recover got=%h lat=%0d required=%h lat=4", y, lat, ref_inv(x));
    end
  endtask

  task automatic test_round_trip();
    state_t x, y;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      x = rand_state();
      run_one(i % 3, ref_mix(x), y, lat);
      checks++;
      if (y !== x) begin
        errors++;
        $display("FAIL round_trip dut=%0d iter=%0d got=%h required=%h", i % 3, i, y, x);
      end
    end
  endtask

  initial begin
    rst       = 3'b111;
    in_valid  = 3'b000;
    out_ready = 3'b000;
    for (int k = 0; k < 3; k++) in_s[k] = '0;
    test_reset();
    test_single_column();
    test_known_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
